// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) xtime, state-machine encoding and
// the round-count rule used to validate the top-level key-size parameters.
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*b +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte k of the state sits at bits [8k:8k+7]; column c holds bytes 4c..4c+3.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:127] state_i,
  input  logic [0:127] rk_i,
  input  logic         last_i,
  output logic [0:127] state_o
);

  logic [7:0]   sb [4*NB];
  logic [7:0]   sr [4*NB];
  logic [7:0]   mc [4*NB];
  logic [0:127] mixed;

  always_comb begin
    for (int k = 0; k < 4*NB; k++) begin
      sb[k] = sbox(state_i[8*k +: 8]);
    end
    // Row r of the output column c takes row r of input column c+r.
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%NB)+r];
      end
    end
    for (int c = 0; c < NB; c++) begin
      mc[4*c]   = xtime(sr[4*c])   ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c]   ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c]   ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int k = 0; k < 4*NB; k++) begin
      mixed[8*k +: 8] = last_i ? sr[k] : mc[k];
    end
    state_o = mixed ^ rk_i;
  end

endmodule

// File: rtl/aes_enc_seq.sv
// Iterative AES encryptor, one round per clock: ciphertext valid nr+1 cycles after accept.
// Output is held while out_ready is low; a new block can be accepted in the same cycle the result leaves.
module aes_enc_seq
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:127]           in_data,
  input  logic [0:128*(nr+1)-1]  key_e,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:127]           out_data,
  output logic                   busy,
  output logic [3:0]             rnd
);

  if (nr != nr_from_nk(nk) || !(nk == 4 || nk == 6 || nk == 8)) begin : g_bad_cfg
    $fatal(1, "aes_enc_seq: nk must be 4, 6 or 8 and nr must equal nk+6");
  end

  localparam logic [3:0] NR_W = 4'(nr);

  aes_fsm_e     fsm_q, fsm_d;
  logic [0:127] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] rk_a [0:nr];
  logic [0:127] round_out;
  logic         last_rnd;
  logic         accept;

  for (genvar r = 0; r <= nr; r++) begin : g_rk
    assign rk_a[r] = key_e[128*r +: 128];
  end

  assign last_rnd = (rnd_q == NR_W);

  aes_round u_round (
    .state_i (state_q),
    .rk_i    (rk_a[rnd_q]),
    .last_i  (last_rnd),
    .state_o (round_out)
  );

  assign in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q != ST_IDLE);
  assign out_data  = state_q;
  assign rnd       = rnd_q;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_data ^ rk_a[0];
          rnd_d   = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        if (last_rnd) fsm_d = ST_DONE;
        else          rnd_d = rnd_q + 4'd1;
      end
      ST_DONE: begin
        // The result leaves and the next block enters on the same edge.
        if (out_ready) begin
          if (in_valid) begin
            state_d = in_data ^ rk_a[0];
            rnd_d   = 4'd1;
            fsm_d   = ST_ROUND;
          end else begin
            rnd_d = 4'd0;
            fsm_d = ST_IDLE;
          end
        end
      end
      default: begin
        rnd_d = 4'd0;
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rnd_q   <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_seq.sv
// Directed bench for aes_enc_seq: FIPS-197 vectors for AES-128/256 plus stall,
// back-to-back, mid-flight reset and ignored-input sequences.
module tb_aes_enc_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv [2];
  logic         ir [2];
  logic         ov [2];
  logic         ordy [2];
  logic         bsy [2];
  logic [0:127] id [2];
  logic [0:127] od [2];
  logic [3:0]   rn [2];
  logic [0:1407] ek128;
  logic [0:1919] ek256;

  int checks = 0;
  int failures = 0;

  aes_enc_seq #(.nk(4), .nr(10)) dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .key_e(ek128), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .busy(bsy[0]), .rnd(rn[0])
  );

  aes_enc_seq #(.nk(8), .nr(14)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .key_e(ek256), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .busy(bsy[1]), .rnd(rn[1])
  );

  typedef struct {
    int            u;
    logic [0:255]  key;
    logic [127:0]  pt;
    logic [127:0]  ct;
    int            lat;
  } vec_t;

  localparam logic [0:255]  KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255]  KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0]  PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0]  CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0]  PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0]  CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] res;
    int            nw;
    nw  = 4 * (nk + 7);
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      res[32*i +: 32] = w[i];
    end
    return res;
  endfunction

  task automatic start(input int u, input logic [0:127] pt);
    iv[u] = 1'b1;
    id[u] = pt;
    @(posedge clk); #1;
    iv[u] = 1'b0;
  endtask

  // lat counts clock edges from the accept edge (edge 1) to the first edge after which out_valid is seen.
  task automatic wait_out(input int u, input int l0, output int lat);
    lat = l0;
    while (!ov[u] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input int u);
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
  endtask

  vec_t          tv [5];
  logic [0:1919] tmp;
  int            lat;
  int            n;

  initial begin
    tv[0] = '{0, KEY_C1, PT_C, CT_C1, 11};
    tv[1] = '{0, KEY_B, PT_B, CT_B, 11};
    tv[2] = '{0, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 11};
    tv[3] = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              PT_C, 128'h8ea2b7ca516745bfeafc49904b496089, 15};
    tv[4] = '{1, 256'h0, 128'h0, 128'hdc95c078a2408989ad48a21492842087, 15};

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b0; id[u] = '0;
    end
    ek128 = '0;
    ek256 = '0;
    #12;
    chk("rst_out_valid", 128'(ov[0]), 128'd0);
    chk("rst_rnd", 128'(rn[0]), 128'd0);
    chk("rst_in_ready", 128'(ir[0]), 128'd1);
    chk("rst_busy", 128'(bsy[0]), 128'd0);
    chk("rst_out_data", od[0], 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      tmp = expand(tv[i].key, (tv[i].u == 0) ? 4 : 8);
      if (tv[i].u == 0) ek128 = tmp[0:1407];
      else              ek256 = tmp;
      start(tv[i].u, tv[i].pt);
      wait_out(tv[i].u, 1, lat);
      chk($sformatf("vec%0d_ct", i), od[tv[i].u], tv[i].ct);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tv[i].lat));
      drain(tv[i].u);
    end

    // Consumer stalls for 5 cycles in DONE.
    tmp = expand(KEY_C1, 4);
    ek128 = tmp[0:1407];
    start(0, PT_C);
    wait_out(0, 1, lat);
    chk("stall_latency", 128'(lat), 128'd11);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_data", c), od[0], CT_C1);
      chk($sformatf("stall%0d_valid", c), 128'(ov[0]), 128'd1);
      chk($sformatf("stall%0d_in_ready", c), 128'(ir[0]), 128'd0);
      chk($sformatf("stall%0d_rnd", c), 128'(rn[0]), 128'd10);
      @(posedge clk); #1;
    end

    // Back-to-back: release the result and accept a new block (new key) on the same edge.
    tmp = expand(KEY_B, 4);
    ek128 = tmp[0:1407];
    iv[0] = 1'b1; id[0] = PT_B; ordy[0] = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(ir[0]), 128'd1);
    chk("b2b_old_data", od[0], CT_C1);
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b0;
    chk("b2b_valid_low", 128'(ov[0]), 128'd0);
    chk("b2b_busy", 128'(bsy[0]), 128'd1);
    chk("b2b_rnd", 128'(rn[0]), 128'd1);
    wait_out(0, 1, lat);
    chk("b2b_latency", 128'(lat), 128'd11);
    chk("b2b_ct", od[0], CT_B);
    drain(0);

    // Reset while the block is at round 5.
    start(0, PT_B);
    n = 0;
    while (rn[0] != 4'd5 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_reached_rnd5", 128'(rn[0]), 128'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(ov[0]), 128'd0);
    chk("midrst_rnd", 128'(rn[0]), 128'd0);
    chk("midrst_in_ready", 128'(ir[0]), 128'd1);
    chk("midrst_busy", 128'(bsy[0]), 128'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle_after", 128'(bsy[0]), 128'd0);
    start(0, PT_B);
    wait_out(0, 1, lat);
    chk("midrst_next_latency", 128'(lat), 128'd11);
    chk("midrst_next_ct", od[0], CT_B);
    drain(0);

    // in_valid toggling with junk data during ROUND must be ignored.
    tmp = expand(KEY_C1, 4);
    ek128 = tmp[0:1407];
    start(0, PT_C);
    for (int c = 0; c < 6; c++) begin
      iv[0] = (c % 2 == 0);
      id[0] = 128'hdeadbeef_cafef00d_01234567_89abcdef ^ 128'(c);
      #1;
      chk($sformatf("toggle%0d_in_ready", c), 128'(ir[0]), 128'd0);
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    id[0] = '0;
    wait_out(0, 7, lat);
    chk("toggle_latency", 128'(lat), 128'd11);
    chk("toggle_ct", od[0], CT_C1);
    drain(0);
    chk("toggle_idle_busy", 128'(bsy[0]), 128'd0);
    chk("toggle_idle_rnd", 128'(rn[0]), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_enc_seq.md
AES_ENC_SEQ -- requirements
Module: aes_enc_seq

Interface
REQ-001 The block SHALL have parameter nk, default 4, meaning key length in 32-bit words (4/6/8).
REQ-002 The block SHALL have parameter nr, default 10, meaning number of rounds; nr SHALL equal nk+6, and elaboration SHALL fail otherwise.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: plaintext block offered.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: block can accept plaintext.
REQ-007 The block SHALL have the port in_data, input, [0:127]: plaintext; state byte k = bits [8k:8k+7], k = 0..15, column-major as in FIPS-197.
REQ-008 The block SHALL have the port key_e, input, [0:128*(nr+1)-1]: expanded key; round key r = bits [128r:128r+127].
REQ-009 The block SHALL have the port out_valid, output, 1 bit: ciphertext available.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: consumer accepts ciphertext.
REQ-011 The block SHALL have the port out_data, output, [0:127]: ciphertext, same byte ordering as in_data.
REQ-012 The block SHALL have the port busy, output, 1 bit: high in ROUND or DONE.
REQ-013 The block SHALL have the port rnd, output, 4 bits: current round index, for debug and key-store addressing.

Function
REQ-014 The FSM SHALL have the states IDLE, ROUND and DONE; after reset it SHALL be in IDLE.
REQ-015 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; it SHALL be 0 in ROUND.
REQ-016 On accept (in_valid & in_ready): state <= in_data XOR rk0; rnd <= 1; the FSM SHALL go to ROUND.
REQ-017 Each ROUND cycle with rnd<nr: state <= MixColumns(ShiftRows(SubBytes(state))) XOR rk[rnd]; rnd <= rnd+1.
REQ-018 The ROUND cycle with rnd==nr: state <= ShiftRows(SubBytes(state)) XOR rk[nr], with MixColumns bypassed; the FSM SHALL go to DONE.
REQ-019 Latency SHALL be exactly nr+1 cycles from the accept edge to the first cycle with out_valid=1 (11/13/15 for AES-128/192/256).
REQ-020 out_valid SHALL be 1 only in DONE; out_data SHALL equal the state register and SHALL be held stable while out_valid & !out_ready.
REQ-021 DONE with out_ready=1 and in_valid=0: the FSM SHALL go to IDLE.
REQ-022 DONE with out_ready=1 and in_valid=1: the output handshake and the new accept SHALL both complete in the same cycle, and the FSM SHALL go to ROUND with no bubble.
REQ-023 in_valid while in ROUND SHALL be ignored; no data SHALL be lost, because in_ready=0.
REQ-024 key_e SHALL be required stable from the accept edge to the final ROUND edge; the block SHALL NOT register key_e.
REQ-025 rnd SHALL read 0 in IDLE, 1..nr in ROUND, and nr in DONE; it SHALL NOT wrap past nr.
REQ-026 The S-box SHALL be the FIPS-197 forward S-box applied to all 16 bytes independently.
REQ-027 MixColumns SHALL use GF(2^8) with polynomial 0x11B; xtime(b) = (b<<1) XOR (0x1B if b[msb]).

Reset
REQ-028 rst_n=0 SHALL immediately force: FSM=IDLE, rnd=0, state=0, out_valid=0, busy=0, in_ready=1 (while deasserted-reset IDLE).
REQ-029 Reset mid-operation SHALL abandon the block in flight with no output; the first accept after reset release SHALL behave as from power-up.
REQ-030 Reset release SHALL be synchronised externally; the block SHALL sample rst_n only asynchronously.

Structure
REQ-031 Package aes_pkg SHALL hold: the sbox function, xtime, the NB=4 constant, the FSM state enum and the nr-from-nk check constant.
REQ-032 One sub-module aes_round SHALL be combinational (state, round key, last flag -> next state), instantiated once and reused for every round.
REQ-033 Only the 128-bit state register, rnd and the FSM SHALL be sequential.

Verification
REQ-034 The bench SHALL cover: AES-128, pt 00112233445566778899aabbccddeeff, key 000102..0f expanded -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 11.
REQ-035 The bench SHALL cover: AES-256 (nk=8, nr=14), same pt, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 at cycle 15.
REQ-036 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0, rnd=nr.
REQ-037 The bench SHALL cover: back-to-back, in_valid=1 with out_ready=1 in DONE -> second ciphertext 11 cycles later, no idle cycle.
REQ-038 The bench SHALL cover: rst_n pulsed low at rnd=5 -> out_valid=0, rnd=0, in_ready=1 at once; next vector correct.
REQ-039 The bench SHALL cover: in_valid toggled during ROUND -> no accept, result unchanged.
